// File: rtl/cpu_clock_ctrl.sv
// Run/halt/single-step clock-enable generator for the LC-3b pipeline.
// Divides clk by a programmable ratio and gates the resulting cpu_ce pulses through a debug FSM.
module cpu_clock_ctrl #(
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 2,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 div_load,
    input  logic [DIV_WIDTH-1:0] div_value,
    input  logic                 run,
    input  logic                 halt,
    input  logic                 step_req,
    output logic                 cpu_ce,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] ce_count
);

    typedef enum logic [1:0] {HALTED, RUNNING, STEPPING} state_e;

    localparam logic [DIV_WIDTH-1:0] DIV_RST = (DEFAULT_DIV == 0) ? DIV_WIDTH'(1) : DIV_WIDTH'(DEFAULT_DIV);

    state_e                 state_q, state_d;
    logic [DIV_WIDTH-1:0]   div_q, div_d;
    logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   ce_count_q, ce_count_d;
    logic                   step_q;

    logic [DIV_WIDTH-1:0]   div_eff;
    logic [DIV_WIDTH-1:0]   cnt_inc;
    logic                   cnt_last;
    logic                   step_edge;

    assign div_eff   = (div_q == '0) ? DIV_WIDTH'(1) : div_q;
    assign cnt_last  = (cnt_q == div_eff - DIV_WIDTH'(1));
    assign cnt_inc   = cnt_last ? '0 : cnt_q + DIV_WIDTH'(1);
    assign step_edge = step_req & ~step_q;

    // Register-decoded only, so the pipeline never sees a combinational input path.
    assign cpu_ce   = (state_q != HALTED) && cnt_last;
    assign busy     = (state_q != HALTED);
    assign ce_count = ce_count_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        ce_count_d = ce_count_q + {{(CNT_WIDTH-1){1'b0}}, cpu_ce};

        case (state_q)
            HALTED: begin
                cnt_d = '0;
                if (!halt) begin
                    if (run)            state_d = RUNNING;
                    else if (step_edge) state_d = STEPPING;
                end
            end
            RUNNING: begin
                if (halt) begin
                    state_d = HALTED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            STEPPING: begin
                // Leaving on the pulse cycle guarantees exactly one pulse per step.
                if (halt || cpu_ce) begin
                    state_d = HALTED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = HALTED;
                cnt_d   = '0;
            end
        endcase

        if (div_load) begin
            div_d = div_value;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HALTED;
            div_q      <= DIV_RST;
            cnt_q      <= '0;
            step_q     <= 1'b0;
            ce_count_q <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            step_q     <= step_req;
            ce_count_q <= ce_count_d;
        end
    end

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Scoreboarded bench for cpu_clock_ctrl: a time-based reference model predicts each cycle's
// outputs, a negedge monitor pops and compares them against the DUT.
module tb_cpu_clock_ctrl;

    localparam int DW = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          div_load = 1'b0;
    logic [DW-1:0] div_value = '0;
    logic          run = 1'b0;
    logic          halt = 1'b0;
    logic          step_req = 1'b0;
    logic          cpu_ce;
    logic          busy;
    logic [CW-1:0] ce_count;

    always #5 clk = ~clk;

    cpu_clock_ctrl #(.DIV_WIDTH(DW), .DEFAULT_DIV(2), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .div_load(div_load), .div_value(div_value),
        .run(run), .halt(halt), .step_req(step_req),
        .cpu_ce(cpu_ce), .busy(busy), .ce_count(ce_count)
    );

    typedef struct {
        logic          ce;
        logic          busy;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: pulses occur every d cycles counted from the cycle the
    // current period started (start), i.e. at start+d-1, start+2d-1, ...
    int   m_mode  = 0;   // 0 halted, 1 running, 2 stepping
    int   m_d     = 2;
    int   m_start = 0;
    int   m_cyc   = 0;
    int   m_count = 0;
    bit   m_sprev = 0;

    function automatic bit m_pulse(int cyc);
        return (m_mode != 0) && (((cyc - m_start) % m_d) == m_d - 1);
    endfunction

    task automatic tick();
        exp_t e;
        bit   ce_now, sedge;
        ce_now = m_pulse(m_cyc);
        if (rst) begin
            m_mode = 0; m_d = 2; m_count = 0; m_sprev = 0;
        end else begin
            if (ce_now) m_count = (m_count + 1) % (1 << CW);
            sedge   = step_req && !m_sprev;
            m_sprev = step_req;
            case (m_mode)
                0: if (!halt) begin
                       if (run)        begin m_mode = 1; m_start = m_cyc + 1; end
                       else if (sedge) begin m_mode = 2; m_start = m_cyc + 1; end
                   end
                1: if (halt) m_mode = 0;
                default: if (halt || ce_now) m_mode = 0;
            endcase
            if (div_load) begin
                m_d     = (div_value == 0) ? 1 : int'(div_value);
                m_start = m_cyc + 1;
            end
        end
        m_cyc  = m_cyc + 1;
        e.ce   = m_pulse(m_cyc);
        e.busy = (m_mode != 0);
        e.cnt  = CW'(m_count);
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks += 3;
            if (cpu_ce !== e.ce) begin
                n_fail++;
                $display("FAIL cpu_ce t=%0t got=%b exp=%b", $time, cpu_ce, e.ce);
            end
            if (busy !== e.busy) begin
                n_fail++;
                $display("FAIL busy t=%0t got=%b exp=%b", $time, busy, e.busy);
            end
            if (ce_count !== e.cnt) begin
                n_fail++;
                $display("FAIL ce_count t=%0t got=%0d exp=%0d", $time, ce_count, e.cnt);
            end
        end
    end

    initial begin
        int budget;
        // reset with run held high
        rst = 1'b1; run = 1'b1;
        ticks(2);
        rst = 1'b0; run = 1'b0;
        ticks(2);
        // default divisor of 2 after reset
        run = 1'b1; ticks(7);
        run = 1'b0; halt = 1'b1; ticks(2); halt = 1'b0;

        // run at divisor 4
        div_load = 1'b1; div_value = 16'd4; tick();
        div_load = 1'b0; run = 1'b1; ticks(14);
        run = 1'b0; halt = 1'b1; tick(); halt = 1'b0; ticks(2);

        // single step, divisor 3, request held high
        div_load = 1'b1; div_value = 16'd3; tick(); div_load = 1'b0;
        step_req = 1'b1; ticks(20);
        step_req = 1'b0; ticks(2);

        // run and halt together from HALTED
        run = 1'b1; halt = 1'b1; ticks(5);
        run = 1'b0; halt = 1'b0; ticks(1);

        // halt mid-step at cnt=1
        step_req = 1'b1; ticks(2);
        halt = 1'b1; tick();
        halt = 1'b0; step_req = 1'b0; ticks(4);

        // divisor 0 loaded while running
        run = 1'b1; ticks(4);
        div_load = 1'b1; div_value = 16'd0; tick(); div_load = 1'b0;
        ticks(8);
        run = 1'b0; halt = 1'b1; tick(); halt = 1'b0;

        // counter wrap at divisor 1
        div_load = 1'b1; div_value = 16'd1; tick(); div_load = 1'b0;
        run = 1'b1; ticks(17);
        run = 1'b0; halt = 1'b1; tick(); halt = 1'b0; ticks(2);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 63) == 0);
            div_load  = ($urandom_range(0, 15) == 0);
            div_value = DW'($urandom_range(0, 5));
            run       = ($urandom_range(0, 3) != 0) ? run : ~run;
            halt      = ($urandom_range(0, 9) == 0);
            step_req  = ($urandom_range(0, 3) == 0) ? ~step_req : step_req;
            tick();
        end
        rst = 1'b0; div_load = 1'b0; run = 1'b0; halt = 1'b0; step_req = 1'b0;
        ticks(3);

        budget = 0;
        while (exp_q.size() > 0 && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
